// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one slave bus between an instruction-fetch master (0) and a data master (1).
// Define BUS_TIMEOUT_EN to abort transfers whose slave stalls for TIMEOUT cycles and raise a sticky bus_error.
module bus_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    input  logic        s_ready,
    output logic [7:0]  s_enables,
    output logic        bus_error
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        owner;
    logic        last_grant;
    logic        grant;
    logic        grant_valid;
    logic        abort;
    logic        finish;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  sel_q;
    logic [31:0] rdata0_q;
    logic [31:0] rdata1_q;

    if (TIMEOUT < 1 || TIMEOUT >= (1 << CNT_W)) begin : g_bad_cfg
        $error("bus_arbiter: TIMEOUT must lie in 1 .. 2**CNT_W-1");
    end

    // On a tie the master that did not win last time gets the bus.
    always_comb begin
        grant_valid = m0_valid | m1_valid;
        if (m0_valid && m1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = m1_valid;
        end
    end

`ifdef BUS_TIMEOUT_EN
    logic [CNT_W-1:0] count;
    logic             error_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            error_q <= 1'b0;
        end else begin
            if (state == IDLE) begin
                count <= '0;
            end else if (state == BUSY && !s_ready && count != '1) begin
                count <= count + 1'b1;
            end
            if (abort) begin
                error_q <= 1'b1;
            end
        end
    end

    assign abort     = (state == BUSY) && !s_ready && (count == CNT_W'(TIMEOUT - 1));
    assign bus_error = error_q;
`else
    assign abort     = 1'b0;
    assign bus_error = 1'b0;
`endif

    assign finish = (state == BUSY) && (s_ready || abort);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            sel_q      <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && grant_valid) begin
                owner      <= grant;
                last_grant <= grant;
                addr_q     <= grant ? m1_addr  : m0_addr;
                wdata_q    <= grant ? m1_wdata : m0_wdata;
                wstrb_q    <= grant ? m1_wstrb : m0_wstrb;
                sel_q      <= (grant ? m1_addr[31] : m0_addr[31]) ? 2'b10 : 2'b01;
            end
            if (finish) begin
                if (owner) begin
                    rdata1_q <= s_ready ? s_rdata : 32'hFFFF_FFFF;
                end else begin
                    rdata0_q <= s_ready ? s_rdata : 32'hFFFF_FFFF;
                end
            end
            // Address and data return to zero so an idle bus shows nothing stale.
            if (state == RESP) begin
                addr_q  <= '0;
                wdata_q <= '0;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_valid) next_state = BUSY;
            BUSY:    if (s_ready || abort) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        s_valid   = 1'b0;
        s_enables = 8'h00;
        s_wstrb   = 4'h0;
        m0_ready  = 1'b0;
        m1_ready  = 1'b0;
        if (state == BUSY) begin
            s_valid   = 1'b1;
            s_enables = {6'b0, sel_q};
            s_wstrb   = wstrb_q;
        end
        if (state == RESP) begin
            m0_ready = ~owner;
            m1_ready = owner;
        end
        s_addr   = addr_q;
        s_wdata  = wdata_q;
        m0_rdata = rdata0_q;
        m1_rdata = rdata1_q;
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scoreboard bench for bus_arbiter: expected completions are queued when a request is driven
// and popped when the owning master sees its ready pulse.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ready, m1_ready;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [31:0] s_rdata;
    logic        s_ready;
    logic [7:0]  s_enables;
    logic        bus_error;

    typedef struct {
        logic        master;
        logic [31:0] rdata;
    } exp_t;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.TIMEOUT(64), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_rdata(s_rdata), .s_ready(s_ready), .s_enables(s_enables), .bus_error(bus_error)
    );

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic m, input logic v, input logic [31:0] a,
                                 input logic [31:0] w, input logic [3:0] s);
        if (!m) begin
            m0_valid = v; m0_addr = a; m0_wdata = w; m0_wstrb = s;
        end else begin
            m1_valid = v; m1_addr = a; m1_wdata = w; m1_wstrb = s;
        end
    endtask

    // Called in the response cycle: the oldest queued completion must be the one presented.
    task automatic check_response();
        exp_t e;
        if (sbq.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL sb_underflow: observed ready with empty scoreboard, expected none");
            return;
        end
        e = sbq.pop_front();
        checkOutput("ready_owner", e.master ? m1_ready : m0_ready, 1);
        checkOutput("ready_other", e.master ? m0_ready : m1_ready, 0);
        checkOutput("rdata", e.master ? m1_rdata : m0_rdata, e.rdata);
    endtask

    task automatic do_transfer(input logic m, input logic [31:0] a, input logic [31:0] w,
                               input logic [3:0] s, input int waits, input logic [31:0] rd);
        applyStimulus(m, 1, a, w, s);
        s_ready = 0;
        s_rdata = rd;
        sbq.push_back('{m, rd});
        tick();
        checkOutput("busy_s_valid", s_valid, 1);
        checkOutput("busy_s_addr", s_addr, a);
        checkOutput("busy_s_wdata", s_wdata, w);
        checkOutput("busy_s_wstrb", s_wstrb, s);
        checkOutput("busy_s_enables", s_enables, a[31] ? 8'h02 : 8'h01);
        repeat (waits) begin
            tick();
            checkOutput("wait_s_addr", s_addr, a);
            checkOutput("wait_readies", {m0_ready, m1_ready}, 0);
        end
        s_ready = 1;
        tick();
        s_ready = 0;
        applyStimulus(m, 0, 0, 0, 0);
        checkOutput("resp_s_valid", s_valid, 0);
        checkOutput("resp_s_enables", s_enables, 0);
        checkOutput("resp_s_wstrb", s_wstrb, 0);
        check_response();
        tick();
        checkOutput("idle_readies", {m0_ready, m1_ready}, 0);
        checkOutput("rdata_hold", m ? m1_rdata : m0_rdata, rd);
    endtask

    initial begin
        int n;
        reset = 1;
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        s_ready = 0;
        s_rdata = 0;
        tick();
        tick();
        checkOutput("rst_s_valid", s_valid, 0);
        checkOutput("rst_s_addr", s_addr, 0);
        checkOutput("rst_s_wdata", s_wdata, 0);
        checkOutput("rst_s_wstrb", s_wstrb, 0);
        checkOutput("rst_s_enables", s_enables, 0);
        checkOutput("rst_readies", {m0_ready, m1_ready}, 0);
        checkOutput("rst_m0_rdata", m0_rdata, 0);
        checkOutput("rst_m1_rdata", m1_rdata, 0);
        checkOutput("rst_bus_error", bus_error, 0);
        reset = 0;
        tick();

        $display("[TB] single read and write transfers");
        do_transfer(0, 32'h0000_0010, 32'h0, 4'h0, 0, 32'h1234_5678);
        do_transfer(1, 32'h8000_0004, 32'hCAFE_F00D, 4'hF, 0, 32'h0BAD_BEEF);
        do_transfer(1, 32'h0000_0100, 32'h0, 4'h0, 2, 32'h5555_AAAA);

        $display("[TB] round robin with both masters always requesting");
        reset = 1;
        tick();
        reset = 0;
        applyStimulus(0, 1, 32'h0000_0040, 32'h1111_1111, 4'h0);
        applyStimulus(1, 1, 32'h8000_0080, 32'h2222_2222, 4'h3);
        s_ready = 1;
        for (int i = 0; i < 4; i++) begin
            s_rdata = 32'hA000_0000 + i;
            sbq.push_back('{logic'(i % 2), 32'hA000_0000 + i});
            tick();
            checkOutput("rr_s_addr", s_addr, (i % 2) ? 32'h8000_0080 : 32'h0000_0040);
            checkOutput("rr_s_enables", s_enables, (i % 2) ? 8'h02 : 8'h01);
            tick();
            check_response();
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        s_ready = 0;
        tick();

        $display("[TB] master 1 waits while master 0 is stalled");
        applyStimulus(0, 1, 32'h0000_0200, 32'h0, 4'h0);
        s_rdata = 32'h0F0F_0F0F;
        sbq.push_back('{1'b0, 32'h0F0F_0F0F});
        tick();
        applyStimulus(1, 1, 32'h8000_0300, 32'h3333_4444, 4'h1);
        sbq.push_back('{1'b1, 32'h7777_8888});
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("stall_s_addr", s_addr, 32'h0000_0200);
            checkOutput("stall_s_valid", s_valid, 1);
        end
        s_ready = 1;
        tick();
        s_ready = 0;
        applyStimulus(0, 0, 0, 0, 0);
        check_response();
        s_rdata = 32'h7777_8888;
        tick();
        checkOutput("gap_s_valid", s_valid, 0);
        tick();
        checkOutput("m1_next_s_addr", s_addr, 32'h8000_0300);
        checkOutput("m1_next_s_wstrb", s_wstrb, 4'h1);
        s_ready = 1;
        tick();
        s_ready = 0;
        applyStimulus(1, 0, 0, 0, 0);
        check_response();
        tick();

        $display("[TB] slave that never responds");
        applyStimulus(0, 1, 32'h0000_0400, 32'h0, 4'h0);
        s_ready = 0;
`ifdef BUS_TIMEOUT_EN
        sbq.push_back('{1'b0, 32'hFFFF_FFFF});
        tick();
        n = 1;
        while (!m0_ready && n < 300) begin
            tick();
            n++;
        end
        checkOutput("timeout_busy_cycles", n - 1, 64);
        check_response();
        checkOutput("timeout_bus_error", bus_error, 1);
        applyStimulus(0, 0, 0, 0, 0);
        repeat (5) tick();
        checkOutput("timeout_error_sticky", bus_error, 1);
`else
        n = 0;
        repeat (1000) begin
            tick();
            n++;
        end
        checkOutput("hang_cycles", n, 1000);
        checkOutput("hang_s_valid", s_valid, 1);
        checkOutput("hang_readies", {m0_ready, m1_ready}, 0);
        checkOutput("hang_bus_error", bus_error, 0);
`endif
        reset = 1;
        tick();
        reset = 0;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("post_rst_bus_error", bus_error, 0);
        tick();

        $display("[TB] reset in the middle of a transfer");
        applyStimulus(0, 1, 32'h0000_0500, 32'h0, 4'h0);
        s_rdata = 32'h9999_0000;
        tick();
        tick();
        reset = 1;
        tick();
        checkOutput("mid_rst_s_valid", s_valid, 0);
        checkOutput("mid_rst_s_enables", s_enables, 0);
        checkOutput("mid_rst_readies", {m0_ready, m1_ready}, 0);
        checkOutput("mid_rst_m0_rdata", m0_rdata, 0);
        reset = 0;
        applyStimulus(0, 1, 32'h0000_0600, 32'h0, 4'h0);
        applyStimulus(1, 1, 32'h8000_0700, 32'h0, 4'h0);
        s_ready = 1;
        s_rdata = 32'h6666_6666;
        sbq.push_back('{1'b0, 32'h6666_6666});
        tick();
        checkOutput("tie_after_rst_s_addr", s_addr, 32'h0000_0600);
        tick();
        s_ready = 0;
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        check_response();
        tick();

        checkOutput("sb_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
